// File: rtl/z_core_pkg.sv
// Shared decode definitions: opcodes, immediate formats, EX-stage payload and immediate generator.
package z_core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Operand set and side-band handed to EX.
  typedef struct packed {
    logic [XLEN-1:0]   alu_in1;
    logic [XLEN-1:0]   alu_in2;
    logic [6:0]        inst_type;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              illegal;
  } ex_bus_t;

  // Sign-extended immediate from instruction bits [31:7] (opcode bits never contribute).
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] ib, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{ib[31]}}, ib[31:20]};
      IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B:   imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_U:   imm = {ib[31:12], 12'h000};
      IMM_J:   imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/z_core_decode_stage_if.sv
// Fetch->decode and decode->EX handshake/bus bundle.
//  master: environment side (fetch drives if_*, EX drives ex_ready and consumes ex_*/alu_*)
//  slave : decode stage side
interface z_core_decode_stage_if;
  import z_core_pkg::*;

  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_inst;
  logic [XLEN-1:0]   if_pc;

  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   alu_in1;
  logic [XLEN-1:0]   alu_in2;
  logic [6:0]        alu_inst_type;
  logic [2:0]        alu_funct3;
  logic [6:0]        alu_funct7;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wen;
  logic              ex_illegal;

  modport master (
    output if_valid, if_inst, if_pc, ex_ready,
    input  if_ready, ex_valid, alu_in1, alu_in2, alu_inst_type, alu_funct3, alu_funct7,
           ex_rs2_data, ex_imm, ex_pc, ex_rd, ex_wen, ex_illegal
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready,
    output if_ready, ex_valid, alu_in1, alu_in2, alu_inst_type, alu_funct3, alu_funct7,
           ex_rs2_data, ex_imm, ex_pc, ex_rd, ex_wen, ex_illegal
  );

endinterface

// File: rtl/z_core_reg_file.sv
// 32x32 register file: two async read ports with same-cycle write bypass, one sync write port.
//  clk, rst         : clock, synchronous active-high reset (clears all registers)
//  raddr1/raddr2    : read addresses; rdata1/rdata2 : read data (x0 reads 0)
//  we, waddr, wdata : write port; writes to x0 are dropped
module z_core_reg_file
  import z_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_live;

  assign wr_live = we && (waddr != '0);

  // Register array write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see a write landing this cycle.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_live && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (wr_live && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/z_core_decode_stage.sv
// Decode / operand-fetch stage feeding z_core_alu.
//  clk, rst            : clock, synchronous active-high reset
//  flush               : squash the EX register and block acceptance this cycle
//  wb_en/wb_rd/wb_data : writeback port (register file write, scoreboard clear, read bypass)
//  bus (slave)         : if_* fetch handshake in, ex_*/alu_* registered operand set out
module z_core_decode_stage
  import z_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_INFO = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  z_core_decode_stage_if.slave  bus
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [REG_AW-1:0]   rs1;
  logic [REG_AW-1:0]   rs2;
  logic [REG_AW-1:0]   rd;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;

  logic                use_rs1;
  logic                use_rs2;
  logic                writes;
  logic                legal;
  imm_fmt_e            fmt;
  ex_bus_t             issue;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_d;
  logic                src1_busy;
  logic                src2_busy;
  logic                hazard;
  logic                ready;
  logic                accept;

  logic                ex_valid_q;
  ex_bus_t             ex_q;

  assign opcode = bus.if_inst[6:0];
  assign rd     = bus.if_inst[11:7];
  assign funct3 = bus.if_inst[14:12];
  assign rs1    = bus.if_inst[19:15];
  assign rs2    = bus.if_inst[24:20];

  z_core_reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // Opcode classification: which sources are read, whether rd is written, immediate format.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    writes  = 1'b0;
    legal   = 1'b1;
    fmt     = IMM_NONE;
    case (opcode)
      OP:                  begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1; end
      OP_IMM, LOAD, JALR:  begin use_rs1 = 1'b1; writes = 1'b1; fmt = IMM_I; end
      STORE:               begin use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S; end
      BRANCH:              begin use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B; end
      LUI, AUIPC:          begin writes = 1'b1; fmt = IMM_U; end
      JAL:                 begin writes = 1'b1; fmt = IMM_J; end
      default:             legal = 1'b0;
    endcase
  end

  // Operand selection and side-band for the instruction on the fetch port.
  always_comb begin
    issue           = '0;
    issue.imm       = imm_gen(bus.if_inst[31:7], fmt);
    issue.inst_type = opcode;
    issue.funct3    = funct3;
    issue.rd        = rd;
    issue.pc        = bus.if_pc;
    issue.rs2_data  = rs2_data;
    issue.wen       = writes && (rd != '0);
    issue.illegal   = ~legal;
    if (opcode == LUI)                          issue.alu_in1 = '0;
    else if (opcode == AUIPC || opcode == JAL)  issue.alu_in1 = bus.if_pc;
    else                                        issue.alu_in1 = rs1_data;
    issue.alu_in2 = (opcode == OP || opcode == BRANCH) ? rs2_data : issue.imm;
    // funct7 only carries meaning for R-type and the shift-immediate group.
    if (opcode == OP || (opcode == OP_IMM && funct3 == 3'b101)) issue.funct7 = bus.if_inst[31:25];
  end

  // A source being written back this cycle is served by the bypass, so it does not stall.
  assign src1_busy = use_rs1 && busy[rs1] && !(wb_en && wb_rd == rs1);
  assign src2_busy = use_rs2 && busy[rs2] && !(wb_en && wb_rd == rs2);
  assign hazard    = src1_busy || src2_busy || (issue.wen && busy[rd]);
  assign ready     = ~flush && ~hazard && (~ex_valid_q || bus.ex_ready);
  assign accept    = bus.if_valid && ready;
  assign bus.if_ready = ready;

  // Scoreboard next state: clears first so a same-index set on accept wins.
  always_comb begin
    busy_d = busy;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (flush && ex_valid_q && ex_q.wen) busy_d[ex_q.rd] = 1'b0;
    if (accept && issue.wen) busy_d[issue.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

  // EX register: load on accept, drop to idle on flush or when EX drains without a refill.
  always_ff @(posedge clk) begin
    if (rst || flush || (!accept && ex_valid_q && bus.ex_ready)) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      ex_q.pc    <= RESET_PC_INFO;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_q       <= issue;
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_in1       = ex_q.alu_in1;
  assign bus.alu_in2       = ex_q.alu_in2;
  assign bus.alu_inst_type = ex_q.inst_type;
  assign bus.alu_funct3    = ex_q.funct3;
  assign bus.alu_funct7    = ex_q.funct7;
  assign bus.ex_rs2_data   = ex_q.rs2_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_wen        = ex_q.wen;
  assign bus.ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_z_core_decode_stage.sv
// Bench for z_core_decode_stage: hand-computed vector table, directed multi-cycle sequences
// and a randomized run against a behavioural model of the stage.
module tb_z_core_decode_stage;
  import z_core_pkg::*;

  localparam logic [31:0] RST_PC = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  z_core_decode_stage_if bus ();

  z_core_decode_stage #(.RESET_PC_INFO(RST_PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_valid;
  ex_bus_t     m_ex;

  typedef struct {
    bit          rd1;
    bit          rd2;
    bit          wr;
    bit          ill;
    logic [31:0] imm;
  } info_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] imm;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void chk_ex(string name, ex_bus_t got, ex_bus_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic info_t classify(logic [31:0] i);
    info_t r;
    r = '{default: 0};
    case (i[6:0])
      7'h33: begin r.rd1 = 1; r.rd2 = 1; r.wr = 1; end
      7'h13, 7'h03, 7'h67: begin r.rd1 = 1; r.wr = 1; r.imm = 32'($signed(i[31:20])); end
      7'h23: begin r.rd1 = 1; r.rd2 = 1; r.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h63: begin r.rd1 = 1; r.rd2 = 1;
               r.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h37, 7'h17: begin r.wr = 1; r.imm = {i[31:12], 12'h000}; end
      7'h6F: begin r.wr = 1; r.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] src(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit pending(logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic bit blocked(logic [31:0] i);
    info_t f = classify(i);
    return (f.rd1 && pending(i[19:15])) || (f.rd2 && pending(i[24:20])) ||
           (f.wr && i[11:7] != 5'd0 && m_busy[i[11:7]]);
  endfunction

  function automatic ex_bus_t idle_ex();
    ex_bus_t e;
    e = '0;
    e.pc = RST_PC;
    return e;
  endfunction

  function automatic ex_bus_t predict(logic [31:0] i, logic [31:0] pc);
    info_t   f = classify(i);
    ex_bus_t e;
    logic [31:0] a, b;
    logic [6:0]  op;
    op = i[6:0];
    a  = src(i[19:15]);
    b  = src(i[24:20]);
    e  = '0;
    e.inst_type = op;
    e.funct3    = i[14:12];
    e.rd        = i[11:7];
    e.funct7    = (op == 7'h33 || (op == 7'h13 && i[14:12] == 3'd5)) ? i[31:25] : 7'd0;
    e.rs2_data  = b;
    e.imm       = f.imm;
    e.pc        = pc;
    e.alu_in1   = (op == 7'h37) ? 32'd0 : ((op == 7'h17 || op == 7'h6F) ? pc : a);
    e.alu_in2   = (op == 7'h33 || op == 7'h63) ? b : f.imm;
    e.wen       = f.wr && (i[11:7] != 5'd0);
    e.illegal   = f.ill;
    return e;
  endfunction

  function automatic ex_bus_t observed();
    ex_bus_t g;
    g.alu_in1   = bus.alu_in1;
    g.alu_in2   = bus.alu_in2;
    g.inst_type = bus.alu_inst_type;
    g.funct3    = bus.alu_funct3;
    g.funct7    = bus.alu_funct7;
    g.rs2_data  = bus.ex_rs2_data;
    g.imm       = bus.ex_imm;
    g.pc        = bus.ex_pc;
    g.rd        = bus.ex_rd;
    g.wen       = bus.ex_wen;
    g.illegal   = bus.ex_illegal;
    return g;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    logic [31:0] i;
    i        = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  task automatic idle_in();
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'h0000_0013;
    bus.if_pc    = 32'h0;
    bus.ex_ready = 1'b1;
    flush        = 1'b0;
    wb_en        = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'h0;
  endtask

  // One clock: check if_ready mid-cycle, advance the model over the edge, compare registered state.
  task automatic tick();
    bit          rdy, acc;
    ex_bus_t     nx_ex;
    logic        nx_valid;
    logic [31:0] nx_busy;
    #2;
    rdy = !flush && !blocked(bus.if_inst) && (!m_valid || bus.ex_ready);
    if (!rst) chk("if_ready", 32'(bus.if_ready), 32'(rdy));
    acc      = bus.if_valid && rdy;
    nx_busy  = m_busy;
    nx_ex    = m_ex;
    nx_valid = m_valid;
    if (wb_en) nx_busy[wb_rd] = 1'b0;
    if (flush && m_valid && m_ex.wen) nx_busy[m_ex.rd] = 1'b0;
    if (acc) begin
      nx_ex    = predict(bus.if_inst, bus.if_pc);
      nx_valid = 1'b1;
      if (nx_ex.wen) nx_busy[nx_ex.rd] = 1'b1;
    end else if (flush || (m_valid && bus.ex_ready)) begin
      nx_valid = 1'b0;
      nx_ex    = idle_ex();
    end
    if (rst) begin
      nx_busy  = 32'd0;
      nx_valid = 1'b0;
      nx_ex    = idle_ex();
    end
    @(posedge clk);
    if (rst) for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    else if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    m_busy  = nx_busy;
    m_valid = nx_valid;
    m_ex    = nx_ex;
    #1;
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk_ex("ex_payload", observed(), m_ex);
    chk("scoreboard", 32'(dut.busy), m_busy);
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{32'h00500093, 32'h100, 32'h0,   32'h5,        32'h5,        7'h00, 5'd1,  1'b1, 1'b0};
    tbl[1]  = '{32'h4030D113, 32'h104, 32'h0,   32'h403,      32'h403,      7'h20, 5'd2,  1'b1, 1'b0};
    tbl[2]  = '{32'h407302B3, 32'h108, 32'h0,   32'h0,        32'h0,        7'h20, 5'd5,  1'b1, 1'b0};
    tbl[3]  = '{32'hABCDE3B7, 32'h10C, 32'h0,   32'hABCDE000, 32'hABCDE000, 7'h00, 5'd7,  1'b1, 1'b0};
    tbl[4]  = '{32'h12345417, 32'h200, 32'h200, 32'h12345000, 32'h12345000, 7'h00, 5'd8,  1'b1, 1'b0};
    tbl[5]  = '{32'hFFDFF0EF, 32'h300, 32'h300, 32'hFFFFFFFC, 32'hFFFFFFFC, 7'h00, 5'd1,  1'b1, 1'b0};
    tbl[6]  = '{32'hFE002C23, 32'h304, 32'h0,   32'hFFFFFFF8, 32'hFFFFFFF8, 7'h00, 5'd24, 1'b0, 1'b0};
    tbl[7]  = '{32'h00000863, 32'h308, 32'h0,   32'h0,        32'h10,       7'h00, 5'd16, 1'b0, 1'b0};
    tbl[8]  = '{32'h000000FF, 32'h30C, 32'h0,   32'h0,        32'h0,        7'h00, 5'd1,  1'b0, 1'b1};
    tbl[9]  = '{32'h00100013, 32'h310, 32'h0,   32'h1,        32'h1,        7'h00, 5'd0,  1'b0, 1'b0};
    tbl[10] = '{32'hFFF02483, 32'h314, 32'h0,   32'hFFFFFFFF, 32'hFFFFFFFF, 7'h00, 5'd9,  1'b1, 1'b0};
    tbl[11] = '{32'h00800567, 32'h318, 32'h0,   32'h8,        32'h8,        7'h00, 5'd10, 1'b1, 1'b0};

    m_busy  = 32'd0;
    m_valid = 1'b0;
    m_ex    = idle_ex();
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;

    rst = 1'b1;
    idle_in();
    tick();
    tick();
    chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset_ex_pc", bus.ex_pc, RST_PC);
    rst = 1'b0;
    tick();

    // Vector table: issue each, check the EX register, then retire rd through writeback.
    for (int k = 0; k < 12; k++) begin
      bus.if_valid = 1'b1;
      bus.if_inst  = tbl[k].inst;
      bus.if_pc    = tbl[k].pc;
      tick();
      chk($sformatf("tbl%0d_valid", k), 32'(bus.ex_valid), 32'd1);
      chk($sformatf("tbl%0d_in1", k), bus.alu_in1, tbl[k].in1);
      chk($sformatf("tbl%0d_in2", k), bus.alu_in2, tbl[k].in2);
      chk($sformatf("tbl%0d_imm", k), bus.ex_imm, tbl[k].imm);
      chk($sformatf("tbl%0d_f7_rd_wen_ill", k),
          32'({bus.alu_funct7, bus.ex_rd, bus.ex_wen, bus.ex_illegal}),
          32'({tbl[k].f7, tbl[k].rd, tbl[k].wen, tbl[k].ill}));
      bus.if_valid = 1'b0;
      wb_en = 1'b1; wb_rd = tbl[k].rd; wb_data = 32'h0;
      tick();
      wb_en = 1'b0;
    end

    // RAW stall released by a same-cycle writeback with bypassed operand.
    bus.if_valid = 1'b1; bus.if_inst = 32'h00500093; bus.if_pc = 32'h400;
    tick();
    bus.if_inst = 32'h002081B3; bus.if_pc = 32'h404;
    tick();
    chk("raw_stall_ready", 32'(bus.if_ready), 32'd0);
    tick();
    chk("raw_stall_ready2", 32'(bus.if_ready), 32'd0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    tick();
    chk("raw_bypass_in1", bus.alu_in1, 32'd5);
    chk("raw_bypass_rd", 32'(bus.ex_rd), 32'd3);
    bus.if_valid = 1'b0; wb_rd = 5'd3; wb_data = 32'h77;
    tick();
    wb_en = 1'b0;

    // EX back-pressure holds the register, then flush squashes it and frees rd.
    bus.if_valid = 1'b1; bus.if_inst = 32'h00700213; bus.if_pc = 32'h500; bus.ex_ready = 1'b0;
    tick();
    bus.if_inst = 32'h00100313; bus.if_pc = 32'h504;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("hold_ready", 32'(bus.if_ready), 32'd0);
      chk("hold_in2_rd", {bus.alu_in2[26:0], bus.ex_rd}, {27'd7, 5'd4});
      chk("hold_pc", bus.ex_pc, 32'h500);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_pc", bus.ex_pc, RST_PC);
    chk("flush_busy4", 32'(dut.busy[4]), 32'd0);
    bus.ex_ready = 1'b1;
    tick();
    bus.if_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h0;
    tick();
    wb_en = 1'b0;

    // Reset while stalled.
    bus.if_valid = 1'b1; bus.if_inst = 32'h00500293; bus.if_pc = 32'h600; bus.ex_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_stall_pc", bus.ex_pc, RST_PC);
    chk("rst_stall_in2", bus.alu_in2, 32'd0);
    chk("rst_stall_busy", 32'(dut.busy), 32'd0);
    idle_in();
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.if_inst  = rand_inst();
      bus.if_pc    = $urandom & 32'hFFFF_FFFC;
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      wb_en        = ($urandom_range(0, 2) == 0);
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      rst          = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
